cordic_engine: RTL

Iterative, one-iteration-per-cycle CORDIC engine. It is the responder side of the QR-decomposition controller's CORDIC handshake. A one-cycle `enable` pulse launches either a vectoring operation (angle extraction) or a rotation operation (apply angle). The result is returned with a one-cycle `done` pulse. Outputs hold their value until the next completion.

---
 rtl/cordic_engine.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine, one micro-rotation per clock: vectoring (magnitude/angle)
// or rotation (apply angle), launched by an enable strobe and completed with a done pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for enable; captures operands and mode
// S_PRE   | quadrant fold so the iterations start within +/- pi/2
// S_ITER  | micro-rotation k = 0 .. ITER-1
// S_SCALE | gain compensation, rounding, saturation, register results
// S_DONE  | done pulse; may accept the next enable back-to-back
module cordic_engine #(
    parameter int ITER = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               select,
    input  logic signed [31:0] x_in,
    input  logic signed [31:0] y_in,
    input  logic signed [31:0] z_in,
    output logic signed [31:0] x_out,
    output logic signed [31:0] y_out,
    output logic signed [31:0] z_out,
    output logic               done,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_SCALE,
        S_DONE
    } state_t;

    localparam logic signed [31:0] PI      = 32'sd843314857;
    localparam logic signed [31:0] HALF_PI = 32'sd421657428;
    localparam logic signed [65:0] K_GAIN  = 66'sd652032874;
    localparam logic signed [65:0] RND     = 66'sd536870912;
    localparam logic signed [65:0] SAT_MAX = 66'sd2147483647;
    localparam logic signed [65:0] SAT_MIN = -66'sd2147483648;
    localparam logic [4:0]         K_LAST  = 5'(ITER - 1);

    state_t             state;
    state_t             state_nxt;
    logic [4:0]         k;
    logic               mode_vec;
    logic signed [33:0] x_r;
    logic signed [33:0] y_r;
    logic signed [31:0] z_r;

    logic               launch;
    logic signed [33:0] pre_x;
    logic signed [33:0] pre_y;
    logic signed [31:0] pre_z;
    logic signed [33:0] x_sh;
    logic signed [33:0] y_sh;
    logic signed [31:0] atan_k;
    logic               dir_pos;
    logic signed [33:0] it_x;
    logic signed [33:0] it_y;
    logic signed [31:0] it_z;
    logic signed [31:0] scaled_x;
    logic signed [31:0] scaled_y;

    // round(atan(2^-k) * 2^28)
    function automatic logic signed [31:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_rom = 32'sd210828714;
            5'd1:    atan_rom = 32'sd124459457;
            5'd2:    atan_rom = 32'sd65760959;
            5'd3:    atan_rom = 32'sd33381290;
            5'd4:    atan_rom = 32'sd16755422;
            5'd5:    atan_rom = 32'sd8385879;
            5'd6:    atan_rom = 32'sd4193963;
            5'd7:    atan_rom = 32'sd2097109;
            5'd8:    atan_rom = 32'sd1048571;
            5'd9:    atan_rom = 32'sd524287;
            5'd10:   atan_rom = 32'sd262144;
            5'd11:   atan_rom = 32'sd131072;
            5'd12:   atan_rom = 32'sd65536;
            5'd13:   atan_rom = 32'sd32768;
            5'd14:   atan_rom = 32'sd16384;
            5'd15:   atan_rom = 32'sd8192;
            5'd16:   atan_rom = 32'sd4096;
            5'd17:   atan_rom = 32'sd2048;
            5'd18:   atan_rom = 32'sd1024;
            5'd19:   atan_rom = 32'sd512;
            5'd20:   atan_rom = 32'sd256;
            5'd21:   atan_rom = 32'sd128;
            5'd22:   atan_rom = 32'sd64;
            5'd23:   atan_rom = 32'sd32;
            5'd24:   atan_rom = 32'sd16;
            5'd25:   atan_rom = 32'sd8;
            5'd26:   atan_rom = 32'sd4;
            5'd27:   atan_rom = 32'sd2;
            default: atan_rom = 32'sd0;
        endcase
    endfunction

    function automatic logic signed [31:0] gain_scale(input logic signed [33:0] v);
        logic signed [65:0] v_ext;
        logic signed [65:0] prod;
        v_ext = v;
        prod  = ((v_ext * K_GAIN) + RND) >>> 30;
        if (prod > SAT_MAX) begin
            gain_scale = 32'sh7FFFFFFF;
        end else if (prod < SAT_MIN) begin
            gain_scale = 32'sh80000000;
        end else begin
            gain_scale = $signed(prod[31:0]);
        end
    endfunction

    // DONE behaves like IDLE for launch so a held enable restarts every ITER+3 cycles.
    assign launch = enable && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (enable) state_nxt = S_PRE;
            end
            S_PRE:   state_nxt = S_ITER;
            S_ITER:  if (k == K_LAST) state_nxt = S_SCALE;
            S_SCALE: state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = enable ? S_PRE : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pre_x = x_r;
        pre_y = y_r;
        pre_z = z_r;
        if (mode_vec) begin
            if (x_r[33]) begin
                pre_x = -x_r;
                pre_y = -y_r;
                pre_z = y_r[33] ? -PI : PI;
            end
        end else if (z_r > HALF_PI) begin
            pre_x = -x_r;
            pre_y = -y_r;
            pre_z = z_r - PI;
        end else if (z_r < -HALF_PI) begin
            pre_x = -x_r;
            pre_y = -y_r;
            pre_z = z_r + PI;
        end
    end

    always_comb begin
        x_sh    = x_r >>> k;
        y_sh    = y_r >>> k;
        atan_k  = atan_rom(k);
        dir_pos = mode_vec ? y_r[33] : ~z_r[31];
        if (dir_pos) begin
            it_x = x_r - y_sh;
            it_y = y_r + x_sh;
            it_z = z_r - atan_k;
        end else begin
            it_x = x_r + y_sh;
            it_y = y_r - x_sh;
            it_z = z_r + atan_k;
        end
        scaled_x = gain_scale(x_r);
        scaled_y = gain_scale(y_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            k        <= '0;
            mode_vec <= 1'b0;
            x_r      <= '0;
            y_r      <= '0;
            z_r      <= '0;
            x_out    <= '0;
            y_out    <= '0;
            z_out    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        mode_vec <= select;
                        x_r      <= {{2{x_in[31]}}, x_in};
                        y_r      <= {{2{y_in[31]}}, y_in};
                        z_r      <= select ? 32'sd0 : z_in;
                        k        <= '0;
                    end
                end
                S_PRE: begin
                    x_r <= pre_x;
                    y_r <= pre_y;
                    z_r <= pre_z;
                    k   <= '0;
                end
                S_ITER: begin
                    x_r <= it_x;
                    y_r <= it_y;
                    z_r <= it_z;
                    k   <= (k == K_LAST) ? 5'd0 : k + 5'd1;
                end
                S_SCALE: begin
                    x_out <= scaled_x;
                    y_out <= mode_vec ? z_r : scaled_y;
                    z_out <= z_r;
                end
                default: ;
            endcase
        end
    end

endmodule
